// File: rtl/seq_detect_group_if.sv
// Serial pattern-detector bus: qualified data stream in, match pulses and
// saturating match count out.
interface seq_detect_group_if #(
  parameter int CNT_W = 8
);
  logic             data_valid;
  logic             data;
  logic             clr;
  logic             match;
  logic             not_match;
  logic [CNT_W-1:0] match_cnt;
  logic             cnt_sat;

  modport master (
    output data_valid, data, clr,
    input  match, not_match, match_cnt, cnt_sat
  );

  modport slave (
    input  data_valid, data, clr,
    output match, not_match, match_cnt, cnt_sat
  );
endinterface

// File: rtl/seq_detect_group.sv
// Parametrised serial sync-word checker: framed or sliding window compare
// against a masked pattern, with a saturating match counter.
module seq_detect_group #(
  parameter int               WIDTH   = 6,
  parameter logic [WIDTH-1:0] PATTERN = WIDTH'(6'b011100),
  parameter logic [WIDTH-1:0] MASK    = {WIDTH{1'b1}},
  parameter int               MODE    = 0,
  parameter int               CNT_W   = 8
) (
  input logic               clk,
  input logic               rst_n,
  seq_detect_group_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  logic [WIDTH-1:0] srl_q, srl_next;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_next;
  logic [CNT_W-1:0] cnt_q, cnt_next;
  logic             match_q, not_match_q, sat_q;
  logic             eval, hit, last_bit;

  // The compare looks at srl_next so the bit arriving this cycle closes the window;
  // in sliding mode the fill counter parks at the last index once full.
  always_comb begin
    srl_next     = srl_q;
    bit_cnt_next = bit_cnt_q;
    eval         = 1'b0;
    last_bit     = (bit_cnt_q == LAST_IDX);
    if (bus.data_valid) begin
      srl_next = {srl_q[WIDTH-2:0], bus.data};
      eval     = last_bit;
      if (!last_bit) begin
        bit_cnt_next = bit_cnt_q + 1'b1;
      end else if (MODE == 0) begin
        bit_cnt_next = '0;
      end
    end
    hit      = (((srl_next ^ PATTERN) & MASK) == '0);
    cnt_next = cnt_q;
    if (eval && hit && (cnt_q != '1)) begin
      cnt_next = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      srl_q       <= '0;
      bit_cnt_q   <= '0;
      match_q     <= 1'b0;
      not_match_q <= 1'b0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
    end else if (bus.clr) begin
      srl_q       <= '0;
      bit_cnt_q   <= '0;
      match_q     <= 1'b0;
      not_match_q <= 1'b0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
    end else begin
      srl_q       <= srl_next;
      bit_cnt_q   <= bit_cnt_next;
      match_q     <= eval && hit;
      not_match_q <= eval && !hit;
      cnt_q       <= cnt_next;
      sat_q       <= (cnt_next == '1);
    end
  end

  assign bus.match     = match_q;
  assign bus.not_match = not_match_q;
  assign bus.match_cnt = cnt_q;
  assign bus.cnt_sat   = sat_q;

endmodule
